// File: rtl/pwm_params.sv
// Shared defaults and FSM state type for the PWM preconditioner slice.
package pwm_params;

    localparam int unsigned DEFAULT_WIDTH     = 13;
    localparam int unsigned DEFAULT_TRANS_NUM = 249;
    localparam int unsigned CALC_LATENCY      = 3;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_CALC    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_COMMIT  = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_calc_edge.sv
// Per-channel edge arithmetic: saturate duty/phase, then derive rise/fall
// edge times modulo the cycle. Three register stages, no divider.
module pwm_calc_edge
    import pwm_params::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned SW = WIDTH + 2;

    logic [WIDTH-1:0] s1_c, s1_d, s1_p;
    logic             s1_small;
    logic [SW-1:0]    s2_c, s2_rise_raw, s2_fall_raw;
    logic             s2_small;
    logic [SW-1:0]    rise_a, rise_b, fall_a;

    // Stage 1: clamp duty and phase to the cycle, flag degenerate cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_c     <= '0;
            s1_d     <= '0;
            s1_p     <= '0;
            s1_small <= 1'b0;
        end else begin
            s1_c     <= c;
            s1_d     <= (d > c) ? c : d;
            s1_p     <= (p > c) ? c : p;
            s1_small <= (c < WIDTH'(2));
        end
    end

    // Stage 2: unreduced edge sums; rise lands in [c/2, 2c], fall in [0, 1.5c].
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_c        <= '0;
            s2_rise_raw <= '0;
            s2_fall_raw <= '0;
            s2_small    <= 1'b0;
        end else begin
            s2_c        <= SW'(s1_c);
            s2_rise_raw <= (SW'(s1_c) << 1) - SW'(s1_p) - SW'(s1_d >> 1);
            s2_fall_raw <= SW'(s1_c) - SW'(s1_p) + ((SW'(s1_d) + SW'(1)) >> 1);
            s2_small    <= s1_small;
        end
    end

    // Modulo by conditional subtraction: twice for rise, once for fall.
    always_comb begin
        rise_a = (s2_rise_raw >= s2_c) ? (s2_rise_raw - s2_c) : s2_rise_raw;
        rise_b = (rise_a >= s2_c) ? (rise_a - s2_c) : rise_a;
        fall_a = (s2_fall_raw >= s2_c) ? (s2_fall_raw - s2_c) : s2_fall_raw;
    end

    // Stage 3: register reduced edges; cycles below 2 force both to zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= s2_small ? '0 : WIDTH'(rise_b);
            fall <= s2_small ? '0 : WIDTH'(fall_a);
        end
    end

endmodule

// File: rtl/pwm_preconditioner.sv
// Snapshots per-channel cycle/duty/phase, streams channels through the edge
// pipeline, and publishes all rise/fall values together with a DONE pulse.
module pwm_preconditioner
    import pwm_params::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned TRANS_NUM = DEFAULT_TRANS_NUM
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH*TRANS_NUM-1:0] CYCLE,
    input  logic [WIDTH*TRANS_NUM-1:0] DUTY,
    input  logic [WIDTH*TRANS_NUM-1:0] PHASE,
    output logic [WIDTH*TRANS_NUM-1:0] RISE,
    output logic [WIDTH*TRANS_NUM-1:0] FALL,
    output logic                       DONE
);

    localparam int unsigned IW = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;

    pwm_state_t       state;
    logic [IW-1:0]    idx;
    logic [1:0]       drain_cnt;

    logic [WIDTH-1:0] snap_c [TRANS_NUM];
    logic [WIDTH-1:0] snap_d [TRANS_NUM];
    logic [WIDTH-1:0] snap_p [TRANS_NUM];
    logic [WIDTH-1:0] buf_r  [TRANS_NUM];
    logic [WIDTH-1:0] buf_f  [TRANS_NUM];

    logic [CALC_LATENCY-1:0] vld_pipe;
    logic [IW-1:0]           idx_pipe [CALC_LATENCY];
    logic [WIDTH-1:0]        calc_rise, calc_fall;

    // Pass sequencer: capture, issue every channel, drain pipeline, commit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_CAPTURE;
            idx       <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    state <= ST_CALC;
                    idx   <= '0;
                end
                ST_CALC: begin
                    if (idx == IW'(TRANS_NUM - 1)) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 2'(CALC_LATENCY - 1)) state <= ST_COMMIT;
                    else                                   drain_cnt <= drain_cnt + 2'd1;
                end
                default: state <= ST_CAPTURE;
            endcase
        end
    end

    // Input snapshot, frozen for the rest of the pass.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < TRANS_NUM; i++) begin
                snap_c[i] <= '0;
                snap_d[i] <= '0;
                snap_p[i] <= '0;
            end
        end else if (state == ST_CAPTURE) begin
            for (int unsigned i = 0; i < TRANS_NUM; i++) begin
                snap_c[i] <= CYCLE[i*WIDTH +: WIDTH];
                snap_d[i] <= DUTY[i*WIDTH +: WIDTH];
                snap_p[i] <= PHASE[i*WIDTH +: WIDTH];
            end
        end
    end

    pwm_calc_edge #(.WIDTH(WIDTH)) u_calc (
        .CLK  (CLK),
        .RST  (RST),
        .c    (snap_c[idx]),
        .d    (snap_d[idx]),
        .p    (snap_p[idx]),
        .rise (calc_rise),
        .fall (calc_fall)
    );

    // Channel index and valid flag travel alongside the edge pipeline.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_pipe <= '0;
            for (int unsigned i = 0; i < CALC_LATENCY; i++) idx_pipe[i] <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[CALC_LATENCY-2:0], (state == ST_CALC)};
            idx_pipe[0] <= idx;
            for (int unsigned i = 1; i < CALC_LATENCY; i++) idx_pipe[i] <= idx_pipe[i-1];
        end
    end

    // Result buffer, filled as each channel leaves the pipeline.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < TRANS_NUM; i++) begin
                buf_r[i] <= '0;
                buf_f[i] <= '0;
            end
        end else if (vld_pipe[CALC_LATENCY-1]) begin
            buf_r[idx_pipe[CALC_LATENCY-1]] <= calc_rise;
            buf_f[idx_pipe[CALC_LATENCY-1]] <= calc_fall;
        end
    end

    // Publish all channels at once; DONE marks the cycle new values appear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RISE <= '0;
            FALL <= '0;
            DONE <= 1'b0;
        end else begin
            DONE <= (state == ST_COMMIT);
            if (state == ST_COMMIT) begin
                for (int unsigned i = 0; i < TRANS_NUM; i++) begin
                    RISE[i*WIDTH +: WIDTH] <= buf_r[i];
                    FALL[i*WIDTH +: WIDTH] <= buf_f[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Bench for pwm_preconditioner: pass-level reference model plus directed pins.
module tb_pwm_preconditioner;

    localparam int W = 13;
    localparam int N = 249;
    localparam int P = N + 5;

    logic           CLK;
    logic           RST;
    logic [W*N-1:0] CYCLE, DUTY, PHASE;
    logic [W*N-1:0] RISE, FALL;
    logic           DONE;

    pwm_preconditioner #(.WIDTH(W), .TRANS_NUM(N)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .CYCLE (CYCLE),
        .DUTY  (DUTY),
        .PHASE (PHASE),
        .RISE  (RISE),
        .FALL  (FALL),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc_a [N];
    int duty_a[N];
    int ph_a  [N];
    int pend_r[N], pend_f[N];
    int exp_r [N], exp_f [N];
    bit exp_done = 1'b0;
    int edge_cnt = 0;

    function automatic int m_rise(int c, int d, int p);
        if (c < 2) return 0;
        if (d > c) d = c;
        if (p > c) p = c;
        return (2*c - p - d/2) % c;
    endfunction

    function automatic int m_fall(int c, int d, int p);
        if (c < 2) return 0;
        if (d > c) d = c;
        if (p > c) p = c;
        return (c - p + (d+1)/2) % c;
    endfunction

    function automatic int rise_of(int ch);
        return int'(RISE[ch*W +: W]);
    endfunction

    function automatic int fall_of(int ch);
        return int'(FALL[ch*W +: W]);
    endfunction

    task automatic push_inputs();
        for (int i = 0; i < N; i++) begin
            CYCLE[i*W +: W] = W'(cyc_a[i]);
            DUTY[i*W +: W]  = W'(duty_a[i]);
            PHASE[i*W +: W] = W'(ph_a[i]);
        end
    endtask

    task automatic randomize_all();
        for (int i = 0; i < N; i++) begin
            cyc_a[i]  = int'($urandom_range(2000, 8000));
            duty_a[i] = int'($urandom_range(0, cyc_a[i]));
            ph_a[i]   = int'($urandom_range(0, cyc_a[i]));
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns negedges waited until DONE is seen, or -1 after the budget.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge CLK);
            if (DONE) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Reference model: a pass starts every P edges after reset release; its
    // inputs are the ones present on its first edge and appear after P edges.
    initial forever begin
        @(posedge CLK);
        if (RST) begin
            edge_cnt = 0;
            exp_done = 1'b0;
            for (int i = 0; i < N; i++) begin
                exp_r[i] = 0;
                exp_f[i] = 0;
            end
        end else begin
            edge_cnt++;
            if ((edge_cnt - 1) % P == 0) begin
                for (int i = 0; i < N; i++) begin
                    pend_r[i] = m_rise(cyc_a[i], duty_a[i], ph_a[i]);
                    pend_f[i] = m_fall(cyc_a[i], duty_a[i], ph_a[i]);
                end
            end
            exp_done = (edge_cnt % P == 0);
            if (exp_done) begin
                for (int i = 0; i < N; i++) begin
                    exp_r[i] = pend_r[i];
                    exp_f[i] = pend_f[i];
                end
            end
        end
    end

    // Every out-of-reset cycle: DONE and all channels against the model.
    initial forever begin
        @(negedge CLK);
        if (!RST) begin
            int bad_ch;
            bit bad;
            bad    = (DONE != exp_done);
            bad_ch = 0;
            for (int i = 0; i < N; i++) begin
                if (!bad && (rise_of(i) != exp_r[i] || fall_of(i) != exp_f[i])) begin
                    bad    = 1'b1;
                    bad_ch = i;
                end
            end
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t: DONE=%0b exp %0b ch%0d RISE=%0d exp %0d FALL=%0d exp %0d",
                         $time, DONE, exp_done, bad_ch, rise_of(bad_ch), exp_r[bad_ch],
                         fall_of(bad_ch), exp_f[bad_ch]);
            end
        end
    end

    initial begin
        int cyc;
        RST = 1'b1;
        for (int i = 0; i < N; i++) begin
            cyc_a[i] = 0; duty_a[i] = 0; ph_a[i] = 0;
        end
        push_inputs();
        repeat (3) @(negedge CLK);
        chk("reset_rise0", rise_of(0), 0);
        chk("reset_fall0", fall_of(0), 0);
        chk("reset_done",  int'(DONE), 0);

        // Directed channels, remaining channels random.
        randomize_all();
        cyc_a[0] = 4096; duty_a[0] = 0;    ph_a[0] = 0;
        cyc_a[1] = 4096; duty_a[1] = 1000; ph_a[1] = 2048;
        cyc_a[2] = 4096; duty_a[2] = 4096; ph_a[2] = 0;
        cyc_a[3] = 4096; duty_a[3] = 5000; ph_a[3] = 0;
        cyc_a[4] = 1;    duty_a[4] = 1;    ph_a[4] = 0;
        cyc_a[5] = 0;    duty_a[5] = 3;    ph_a[5] = 7;
        cyc_a[6] = 4096; duty_a[6] = 100;  ph_a[6] = 5000;
        cyc_a[248] = 3000; duty_a[248] = 1; ph_a[248] = 2999;
        push_inputs();
        @(negedge CLK);
        RST = 1'b0;

        wait_done(cyc);
        chk("first_done_latency", cyc, P);
        chk("ch1_rise", rise_of(1), 1548);
        chk("ch1_fall", fall_of(1), 2548);
        chk("ch2_rise_full_duty", rise_of(2), 2048);
        chk("ch2_fall_full_duty", fall_of(2), 2048);
        chk("ch3_rise_sat_duty",  rise_of(3), 2048);
        chk("ch3_fall_sat_duty",  fall_of(3), 2048);
        chk("ch4_rise_cycle1", rise_of(4), 0);
        chk("ch4_fall_cycle1", fall_of(4), 0);
        chk("ch5_rise_cycle0", rise_of(5), 0);
        chk("ch5_fall_cycle0", fall_of(5), 0);
        chk("ch6_rise_sat_phase", rise_of(6), 4046);
        chk("ch6_fall_sat_phase", fall_of(6), 50);

        wait_done(cyc);
        chk("done_period", cyc, P);
        chk("ch0_rise_zero_duty", rise_of(0), 0);
        chk("ch0_fall_zero_duty", fall_of(0), 0);
        chk("ch248_rise", rise_of(248), 1);
        chk("ch248_fall", fall_of(248), 2);

        // Abort a pass at CALC index 100 (DONE cycle is CAPTURE).
        wait_done(cyc);
        chk("done_before_abort", cyc, P);
        repeat (101) @(negedge CLK);
        #2 RST = 1'b1;
        cyc_a[1] = 4096; duty_a[1] = 2000; ph_a[1] = 100;
        push_inputs();
        repeat (2) @(negedge CLK);
        chk("abort_rise1", rise_of(1), 0);
        chk("abort_fall1", fall_of(1), 0);
        chk("abort_done",  int'(DONE), 0);
        @(negedge CLK);
        RST = 1'b0;
        wait_done(cyc);
        chk("done_after_abort", cyc, P);
        chk("post_abort_rise1", rise_of(1), 2996);
        chk("post_abort_fall1", fall_of(1), 900);

        // Random passes with inputs changed at random points mid-pass.
        for (int pass = 0; pass < 100; pass++) begin
            repeat ($urandom_range(0, 240)) @(negedge CLK);
            randomize_all();
            push_inputs();
            wait_done(cyc);
            n_tests++;
            if (cyc < 0) begin
                n_fail++;
                $display("FAIL random_pass_done: pass %0d got no DONE within 400 cycles, expected one", pass);
            end
        end

        repeat (2) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
